octree_sram_port_ctrl: RTL
==========================

# octree_sram_port_ctrl

Single-port request/response controller placed directly upstream of one port of the 1024x32 dual-port octree node SRAM macro. Accepts valid/ready read and write requests from the octree traversal logic, expands byte enables into the macro's 32-bit bit mask, and drives the macro pins. Captures synchronous read data into a backpressure-safe response FIFO. After reset it can optionally zero-fill the whole array before granting access. One instance per macro port; the two instances share no state.

## Interface
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, word width; byte enables are DATA_W/8 wide
- RSP_DEPTH, 4, response FIFO depth (minimum 3 for full read throughput)
- CLEAR_ON_RESET, 1, 1 = zero-fill all 2^ADDR_W words after reset
- RM_VAL, 4'b0010, constant driven on sram_rm
- clk  in  1  clock; macro port clock is the same net
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- req_valid / req_ready  in / out  1  request handshake
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; byte k maps to mask bits 8k+7..8k
- rsp_valid / rsp_ready  out / in  1  read-response handshake
- rsp_rdata  out  DATA_W  read data
- init_done  out  1  high once in RUN
- sram_me, sram_we  out  1  macro chip enable and write enable
- sram_adr  out  ADDR_W; sram_d  out  DATA_W; sram_wem  out  DATA_W
- sram_q  in  DATA_W  macro read data, valid the cycle after sram_me
- sram_test1, sram_rme, sram_ls  out  1  tied 0
- sram_rm  out  4  tied RM_VAL

## Operation
- FSM states: CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET, else RUN.
- CLEAR:
  - clr_addr counts 0..2^ADDR_W-1, one word per cycle.
  - Drives sram_me=1, sram_we=1, sram_wem all ones, sram_d=0, sram_adr=clr_addr.
  - After the last address it moves to RUN; init_done rises on that transition.
  - req_ready=0 throughout.
- RUN:
  - req_ready = (fifo_count + inflight) < RSP_DEPTH. Write requests obey the same condition.
  - On an accepted request (req_valid && req_ready), the macro pins are driven combinationally in the same cycle: sram_me=1, sram_we=req_we, sram_adr=req_addr, sram_d=req_wdata, sram_wem=byte-expanded req_be.
  - With no accepted request: sram_me=0, sram_we=0; sram_adr, sram_d and sram_wem are 0.
- Reads:
  - An accepted read sets the inflight flag.
  - At the next edge, sram_q is pushed into the FIFO and inflight clears.
  - sram_q is never captured when inflight=0.
- Writes:
  - Produce no response and never set inflight.
  - req_be=0 performs an access with an all-zero mask; memory is unchanged.
- Response FIFO:
  - Circular buffer with pointer wrap at RSP_DEPTH.
  - rsp_valid = (count != 0); rsp_rdata = head entry.
  - A push and a pop in the same cycle leave count unchanged.
  - Overflow is impossible by construction; the bench asserts this.
- Responses return strictly in request order.
- Reset mid-operation:
  - FIFO empties and inflight clears; any pending read is discarded.
  - clr_addr returns to 0 and CLEAR restarts from word 0.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
  - sram_me, sram_we, sram_adr, sram_d, sram_wem are 0 while rst=1.
  - Tie-offs always hold their constants.
- CLEAR lasts exactly 2^ADDR_W cycles after reset deasserts; init_done=1 in cycle 2^ADDR_W (0-based).
- Read latency: request accepted in cycle N, macro samples at edge N, FIFO push at edge N+1, rsp_valid=1 in cycle N+2.
- Throughput: back-to-back reads sustain one per cycle when rsp_ready stays high and RSP_DEPTH>=3.
- A write accepted in cycle N updates memory at edge N. A read accepted in cycle N+1 to the same address returns the new data.

## Structure
- Package octree_sram_pkg holds:
  - ADDR_W, DATA_W defaults
  - state enum {CLEAR, RUN}
  - packed struct sram_req_t (we, addr, wdata, be)
  - function be_to_wem() for byte-to-bit mask expansion
- Sub-module octree_sram_rsp_fifo: parameterised synchronous FIFO exposing push, pop, data, count.
- Top level holds the FSM, clear counter, inflight flag and pin muxing.

## Test plan
- Reset with CLEAR_ON_RESET=1, then read addresses 0, 511, 1023 -> init_done rises after exactly 1024 cycles; all reads return 0x00000000.
- Write 0xDEADBEEF to addr 5 with be=4'b0101, then read addr 5 -> response 0x00AD00EF; rsp_valid two cycles after the read is accepted.
- 16 back-to-back reads with rsp_ready=1 -> req_ready never drops after the first; responses arrive in order at one per cycle.
- Hold rsp_ready=0 and issue reads -> exactly RSP_DEPTH (4) accepted, then req_ready=0. Release rsp_ready -> all 4 drain in order and no data is lost.
- Write addr 7 = 0x12345678 in cycle N, read addr 7 in cycle N+1 -> response 0x12345678.
- Assert rst for 1 cycle with 2 responses queued and 1 read in flight -> rsp_valid=0 the next cycle, no stale response ever appears, and CLEAR restarts at address 0.

Source files
------------

// File: rtl/octree_sram_pkg.sv
// Shared types and helpers for the octree node SRAM port controller.
package octree_sram_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {CLEAR, RUN} state_e;

   typedef struct packed {
      logic                      we;
      logic [ADDR_W_DEF-1:0]     addr;
      logic [DATA_W_DEF-1:0]     wdata;
      logic [DATA_W_DEF/8-1:0]   be;
   } sram_req_t;

   // Byte k of the enable selects mask bits 8k+7..8k.
   function automatic logic [DATA_W_DEF-1:0] be_to_wem(input logic [DATA_W_DEF/8-1:0] be);
      logic [DATA_W_DEF-1:0] wem;
      wem = '0;
      for (int k = 0; k < DATA_W_DEF/8; k++) wem[8*k +: 8] = {8{be[k]}};
      return wem;
   endfunction

endpackage

// File: rtl/octree_sram_rsp_fifo.sv
// Synchronous circular-buffer FIFO holding read responses; output is zero when empty.
module octree_sram_rsp_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 32,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !do_pop)      count_d = count_q + 1'b1;
      else if (!push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/octree_sram_port_ctrl.sv
// One-port request/response front end for the octree node SRAM macro, with
// optional post-reset zero fill and a backpressure-safe read response queue.
module octree_sram_port_ctrl
   import octree_sram_pkg::*;
#(
   parameter int         ADDR_W         = ADDR_W_DEF,
   parameter int         DATA_W         = DATA_W_DEF,
   parameter int         RSP_DEPTH      = 4,
   parameter bit         CLEAR_ON_RESET = 1'b1,
   parameter logic [3:0] RM_VAL         = 4'b0010
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                init_done,
   output logic                sram_me,
   output logic                sram_we,
   output logic [ADDR_W-1:0]   sram_adr,
   output logic [DATA_W-1:0]   sram_d,
   output logic [DATA_W-1:0]   sram_wem,
   input  logic [DATA_W-1:0]   sram_q,
   output logic                sram_test1,
   output logic                sram_rme,
   output logic                sram_ls,
   output logic [3:0]          sram_rm
);

   localparam int CW = $clog2(RSP_DEPTH + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              inflight_q, inflight_d;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     occ;
   logic [DATA_W-1:0] fifo_dout;
   logic              req_acc;
   logic              rsp_pop;
   sram_req_t         req;

   assign req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

   // Reads still in the macro count against queue space so a stalled consumer
   // can never cause a push into a full FIFO.
   assign occ = fifo_count + CW'(inflight_q);

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      inflight_d = 1'b0;
      req_ready  = 1'b0;
      req_acc    = 1'b0;
      sram_me    = 1'b0;
      sram_we    = 1'b0;
      sram_adr   = '0;
      sram_d     = '0;
      sram_wem   = '0;
      if (!rst) begin
         case (state_q)
            CLEAR: begin
               sram_me    = 1'b1;
               sram_we    = 1'b1;
               sram_wem   = '1;
               sram_adr   = clr_addr_q;
               clr_addr_d = clr_addr_q + 1'b1;
               if (&clr_addr_q) state_d = RUN;
            end
            RUN: begin
               req_ready = occ < CW'(RSP_DEPTH);
               req_acc   = req_valid && req_ready;
               if (req_acc) begin
                  sram_me    = 1'b1;
                  sram_we    = req.we;
                  sram_adr   = req.addr;
                  sram_d     = req.wdata;
                  sram_wem   = be_to_wem(req.be);
                  inflight_d = !req.we;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
         clr_addr_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         inflight_q <= inflight_d;
      end
   end

   assign rsp_valid = !rst && (fifo_count != '0);
   assign rsp_rdata = rst ? '0 : fifo_dout;
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign init_done = !rst && (state_q == RUN);

   octree_sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(DATA_W)) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q),
      .pop   (rsp_pop),
      .din   (sram_q),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign sram_test1 = 1'b0;
   assign sram_rme   = 1'b0;
   assign sram_ls    = 1'b0;
   assign sram_rm    = RM_VAL;

endmodule
